// File: rtl/knight_comm_pkg.sv
// Shared constants and state encodings for the Knight remote command link.
package knight_comm_pkg;

    localparam logic [7:0]  ACK_POS          = 8'hA5;
    localparam int          DEF_BAUD_DIV     = 434;
    localparam logic [19:0] DEF_TIMEOUT_CLKS = 20'd500000;

    typedef enum logic { WAIT_HI, WAIT_LO } asm_state_e;
    typedef enum logic { TX_IDLE, TX_BUSY } tx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_byte_rx
    import knight_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       busy_o,
    output logic       byte_rdy_o,
    output logic [7:0] data_o,
    output logic       stop_err_o
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

    logic          sync1_q, sync2_q, prev_q;
    logic          busy_q;
    logic [CW-1:0] baud_q;
    logic [3:0]    idx_q;
    logic [7:0]    sh_q;
    logic          rdy_q, err_q;
    logic          start, sample;

    assign start  = !busy_q && prev_q && !sync2_q;
    assign sample = busy_q && (baud_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            busy_q  <= 1'b0;
            baud_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
                baud_q <= HALF;
                idx_q  <= '0;
            end else if (busy_q) begin
                if (sample) begin
                    // idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit
                    baud_q <= FULL;
                    idx_q  <= idx_q + 4'd1;
                    if (idx_q >= 4'd1 && idx_q <= 4'd8)
                        sh_q <= {sync2_q, sh_q[7:1]};
                    if (idx_q == 4'd9) begin
                        busy_q <= 1'b0;
                        if (sync2_q) rdy_q <= 1'b1;
                        else         err_q <= 1'b1;
                    end
                end else begin
                    baud_q <= baud_q - CW'(1);
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign byte_rdy_o = rdy_q;
    assign data_o     = sh_q;
    assign stop_err_o = err_q;

endmodule

// File: rtl/knight_cmd_responder.sv
// Remote link endpoint: assembles 16-bit commands from byte pairs, sends 8-bit responses.
module knight_cmd_responder
    import knight_comm_pkg::*;
#(
    parameter int          BAUD_DIV     = DEF_BAUD_DIV,
    parameter logic [19:0] TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        frm_err
);

    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BCW-1:0] BLAST = BCW'(BAUD_DIV - 1);

    logic       rx_busy, rx_rdy, rx_err;
    logic [7:0] rx_data;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (RX),
        .busy_o    (rx_busy),
        .byte_rdy_o(rx_rdy),
        .data_o    (rx_data),
        .stop_err_o(rx_err)
    );

    // ---------------- command assembler ----------------
    asm_state_e  asm_q, asm_d;
    logic [7:0]  hi_q, hi_d;
    logic [19:0] tmo_q, tmo_d;
    logic [15:0] cmd_q, cmd_d;
    logic        rdy_q, rdy_d;
    logic        frm_q, frm_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= WAIT_HI;
            hi_q  <= '0;
            tmo_q <= '0;
            cmd_q <= '0;
            rdy_q <= 1'b0;
            frm_q <= 1'b0;
        end else begin
            asm_q <= asm_d;
            hi_q  <= hi_d;
            tmo_q <= tmo_d;
            cmd_q <= cmd_d;
            rdy_q <= rdy_d;
            frm_q <= frm_d;
        end
    end

    always_comb begin
        asm_d = asm_q;
        hi_d  = hi_q;
        tmo_d = tmo_q;
        cmd_d = cmd_q;
        rdy_d = rdy_q;
        frm_d = rx_err;
        if (clr_cmd_rdy) rdy_d = 1'b0;
        case (asm_q)
            WAIT_HI: begin
                if (rx_rdy) begin
                    hi_d  = rx_data;
                    tmo_d = '0;
                    rdy_d = 1'b0;
                    asm_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // completing byte overrides a coincident clear
                if (rx_rdy) begin
                    cmd_d = {hi_q, rx_data};
                    rdy_d = 1'b1;
                    asm_d = WAIT_HI;
                end else if (rx_err) begin
                    asm_d = WAIT_HI;
                end else if (!rx_busy) begin
                    if (tmo_q == TIMEOUT_CLKS - 20'd1) begin
                        frm_d = 1'b1;
                        asm_d = WAIT_HI;
                    end else begin
                        tmo_d = tmo_q + 20'd1;
                    end
                end
            end
            default: asm_d = WAIT_HI;
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;
    assign frm_err = frm_q;

    // ---------------- response transmitter ----------------
    tx_state_e      tx_q, tx_d;
    logic [9:0]     sh_q, sh_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [3:0]     bitn_q, bitn_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= TX_IDLE;
            sh_q   <= '1;
            bcnt_q <= '0;
            bitn_q <= '0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            sh_q   <= sh_d;
            bcnt_q <= bcnt_d;
            bitn_q <= bitn_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        tx_d   = tx_q;
        sh_d   = sh_q;
        bcnt_d = bcnt_q;
        bitn_d = bitn_q;
        done_d = done_q;
        case (tx_q)
            TX_IDLE: begin
                if (trmt) begin
                    sh_d   = {1'b1, resp, 1'b0};
                    bcnt_d = '0;
                    bitn_d = '0;
                    done_d = 1'b0;
                    tx_d   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // ones shift in behind the frame, so the line rests high afterwards
                if (bcnt_q == BLAST) begin
                    bcnt_d = '0;
                    sh_d   = {1'b1, sh_q[9:1]};
                    if (bitn_q == 4'd9) begin
                        done_d = 1'b1;
                        tx_d   = TX_IDLE;
                    end else begin
                        bitn_d = bitn_q + 4'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    assign TX      = sh_q[0];
    assign tx_done = done_q;

endmodule

// File: tb/tb_knight_cmd_responder.sv
// Directed + randomized bench for knight_cmd_responder with a byte-level reference model.
module tb_knight_cmd_responder;

    localparam int          B  = 20;
    localparam logic [19:0] TO = 20'd2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        trmt = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX, cmd_rdy, tx_done, frm_err;
    logic [15:0] cmd;

    knight_cmd_responder #(.BAUD_DIV(B), .TIMEOUT_CLKS(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .frm_err    (frm_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int frm_cnt = 0;

    // reference model: pending high byte, last command, ready flag, error count
    bit          hi_valid = 1'b0;
    logic [7:0]  hi_byte = 8'h00;
    logic [15:0] exp_cmd = 16'h0000;
    logic        exp_rdy = 1'b0;
    int          exp_frm = 0;

    always @(negedge clk) if (frm_err === 1'b1) frm_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        RX = 1'b0;
        repeat (B) tick();
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) tick();
        end
        RX = ok;
        repeat (B) tick();
        RX = 1'b1;
        if (!ok) repeat (B) tick();
        if (!ok) begin
            hi_valid = 1'b0;
            exp_frm++;
        end else if (!hi_valid) begin
            hi_byte  = b;
            hi_valid = 1'b1;
            exp_rdy  = 1'b0;
        end else begin
            exp_cmd  = {hi_byte, b};
            exp_rdy  = 1'b1;
            hi_valid = 1'b0;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
        if (hi_valid && n >= int'(TO)) begin
            hi_valid = 1'b0;
            exp_frm++;
        end
    endtask

    task automatic pulse_clr;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_cmd"}, {16'h0, cmd}, {16'h0, exp_cmd});
        chk({tag, "_rdy"}, {31'h0, cmd_rdy}, {31'h0, exp_rdy});
        chk({tag, "_frm"}, frm_cnt, exp_frm);
    endtask

    // send one response and check every bit mid-bit; optional retrigger at clk 100
    task automatic tx_check(input logic [7:0] r, input bit retrig);
        logic [9:0] fr;
        fr   = {1'b1, r, 1'b0};
        resp = r;
        trmt = 1'b1;
        tick();
        trmt = 1'b0;
        resp = 8'($urandom);
        chk("tx_done_clr", {31'h0, tx_done}, 32'h0);
        for (int t = 1; t <= 10 * B; t++) begin
            if (retrig && t == 100) begin
                trmt = 1'b1;
                resp = ~r;
            end
            tick();
            trmt = 1'b0;
            if (t % B == B / 2) chk("tx_bit", {31'h0, TX}, {31'h0, fr[t / B]});
            if (t == 10 * B - 1) chk("tx_done_early", {31'h0, tx_done}, 32'h0);
        end
        chk("tx_done_set", {31'h0, tx_done}, 32'h1);
        chk("tx_idle", {31'h0, TX}, 32'h1);
    endtask

    initial begin
        logic [7:0] b;
        bit ok;

        repeat (3) tick();
        chk("rst_TX", {31'h0, TX}, 32'h1);
        chk("rst_cmd", {16'h0, cmd}, 32'h0);
        chk("rst_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_done", {31'h0, tx_done}, 32'h0);
        chk("rst_frm", {31'h0, frm_err}, 32'h0);
        rst_n = 1'b1;
        gap(B);

        // basic command and consume
        send_byte(8'h43, 1'b1);
        send_byte(8'hF1, 1'b1);
        chk("cmd_43F1", {16'h0, cmd}, 32'h43F1);
        chk("rdy_43F1", {31'h0, cmd_rdy}, 32'h1);
        pulse_clr();
        chk("clr_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("clr_cmd", {16'h0, cmd}, 32'h43F1);

        // ACK frame with an ignored retrigger mid-frame
        tx_check(8'hA5, 1'b1);
        gap(B);

        // inter-byte timeout
        send_byte(8'h2F, 1'b1);
        gap(int'(TO) + 10);
        chk("tmo_frm", frm_cnt, 1);
        chk("tmo_rdy", {31'h0, cmd_rdy}, 32'h0);
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("cmd_4000", {16'h0, cmd}, 32'h4000);
        check_model("after_tmo");

        // bad stop bit, then realignment
        send_byte(8'h77, 1'b0);
        gap(5);
        chk("stop_frm", frm_cnt, 2);
        send_byte(8'h51, 1'b1);
        send_byte(8'h12, 1'b1);
        chk("cmd_5112", {16'h0, cmd}, 32'h5112);

        // new command over an unconsumed one
        send_byte(8'h43, 1'b1);
        send_byte(8'hF1, 1'b1);
        send_byte(8'h60, 1'b1);
        chk("over_rdy_low", {31'h0, cmd_rdy}, 32'h0);
        chk("over_cmd_hold", {16'h0, cmd}, 32'h43F1);
        send_byte(8'h00, 1'b1);
        chk("cmd_6000", {16'h0, cmd}, 32'h6000);
        chk("rdy_6000", {31'h0, cmd_rdy}, 32'h1);

        // reset in the middle of both an RX byte and a TX frame
        resp = 8'h3C;
        trmt = 1'b1;
        tick();
        trmt = 1'b0;
        RX = 1'b0;
        repeat (B) tick();
        RX = 1'b1;
        repeat (B) tick();
        RX = 1'b0;
        repeat (B / 2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_TX", {31'h0, TX}, 32'h1);
        chk("mid_rst_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("mid_rst_cmd", {16'h0, cmd}, 32'h0);
        RX = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        hi_valid = 1'b0;
        exp_cmd  = 16'h0000;
        exp_rdy  = 1'b0;
        gap(B);
        send_byte(8'h43, 1'b1);
        send_byte(8'hF1, 1'b1);
        chk("post_rst_cmd", {16'h0, cmd}, 32'h43F1);
        check_model("post_rst");

        // randomized traffic against the model, with occasional full-duplex responses
        for (int it = 0; it < 36; it++) begin
            if ($urandom_range(0, 15) == 0) gap(int'(TO) + 100 + int'($urandom_range(0, 200)));
            else                            gap(int'($urandom_range(1, 150)));
            if ($urandom_range(0, 3) == 0) pulse_clr();
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            if (it % 6 == 5) begin
                fork
                    send_byte(b, ok);
                    tx_check(8'($urandom), 1'b0);
                join
            end else begin
                send_byte(b, ok);
            end
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/knight_cmd_responder.md
Name: knight_cmd_responder

Overview:
DUT-side end of the remote command link.
- Receives 16-bit commands over UART as two bytes, high byte first, from the remote/bluetooth initiator. Presents each command to the command processor with a ready flag.
- Transmits 8-bit responses back on the same link, e.g. 8'hA5 positive acknowledge after calibration or move completion.
- Sits between the chip RX/TX pins and the command processor inside the Knight top level.

Parameters:
BAUD_DIV, 434, clocks per bit (50 MHz / 115200 baud).
TIMEOUT_CLKS, 20'd500000, max clocks allowed from end of high byte to start bit of low byte before the partial command is discarded.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
RX  input  1  serial in from the remote; idles high; asynchronous to clk
TX  output  1  serial out to the remote; idles high
cmd  output  16  last assembled command {high_byte, low_byte}
cmd_rdy  output  1  high while cmd holds a new, unconsumed command
clr_cmd_rdy  input  1  single-cycle pulse from the command processor consuming cmd
resp  input  8  response byte to send
trmt  input  1  single-cycle pulse; starts transmission of resp
tx_done  output  1  set when the stop bit of a response has finished; cleared by the next accepted trmt
frm_err  output  1  single-cycle pulse on a bad stop bit or an inter-byte timeout

Behaviour:
Reset values:
- TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, frm_err=0.
- Internal RX synchronizer flops preset to 1.
- Both FSMs return to idle.

RX path:
- RX passes through a two-flop synchronizer before any use.
- Start is detected on a falling edge of synchronized RX while the byte receiver is idle.
- The bit counter loads BAUD_DIV/2 on start detect, then BAUD_DIV after each sample, so every sample lands mid-bit.
- Sample order: start, 8 data bits LSB first, stop. The start bit is not re-validated.
- byte_rdy pulses for 1 clk when the stop sample is taken.
- If the stop sample is 0: the byte is discarded, frm_err pulses, and the assembler returns to WAIT_HI.

Assembler FSM:
- WAIT_HI:
  - On byte_rdy: latch high byte, clear timeout counter, go to WAIT_LO.
  - cmd_rdy is cleared on the cycle that high byte's byte_rdy is taken. This is a new command arriving over an unconsumed one.
- WAIT_LO:
  - The timeout counter increments every clk while the byte receiver is idle.
  - On byte_rdy: cmd <= {high, low}, cmd_rdy <= 1 on the next clk edge, go to WAIT_HI.
  - If the counter reaches TIMEOUT_CLKS: pulse frm_err, discard the high byte, go to WAIT_HI. cmd and cmd_rdy are unchanged.
- clr_cmd_rdy clears cmd_rdy. If it coincides with the completing byte_rdy, set wins: the new command is not lost.
- cmd is stable from cmd_rdy rising until the next high byte completes.

TX path:
- TX_IDLE:
  - trmt loads the shift register with {1'b1, resp, 1'b0}, clears tx_done, goes to TX_BUSY.
  - The start bit appears on TX the clk after trmt.
- TX_BUSY:
  - Shift every BAUD_DIV clks, LSB first.
  - After 10 bit-times: set tx_done, TX=1, go to TX_IDLE.
  - trmt while busy is ignored; resp is sampled only at acceptance.
- Total frame is exactly 10*BAUD_DIV clks.
- RX and TX are fully independent and full-duplex. A response may be sent while a command is being received.

Reset mid-operation:
- All state is lost immediately.
- TX returns to 1 within the same asynchronous reset.
- No partial byte survives reset.

Decomposition:
Package knight_comm_pkg:
- ACK_POS = 8'hA5
- default BAUD_DIV
- typedef enum for assembler states {WAIT_HI, WAIT_LO}
- typedef enum for transmit states {TX_IDLE, TX_BUSY}
Sub-modules:
- One natural sub-module: uart_byte_rx. It holds the synchronizer, baud counter, bit counter, shift register, byte_rdy and stop-bit check.
- The assembler FSM, timeout counter and transmitter stay in knight_cmd_responder.

Test Plan:
- Reset, then send bytes 8'h43, 8'hF1 at BAUD_DIV=434 → cmd=16'h43F1 and cmd_rdy rises within 1 clk of the second stop-bit sample. Pulse clr_cmd_rdy → cmd_rdy=0 next clk, cmd still 16'h43F1.
- trmt with resp=8'hA5 → TX carries 0,1,0,1,0,0,1,0,1,1 at 434-clk intervals. tx_done rises 4340 clks after trmt. A second trmt at clk 100 of the frame does not alter the waveform.
- Send 8'h2F then wait TIMEOUT_CLKS+10 with RX idle → one frm_err pulse, cmd_rdy stays 0. A following 8'h40, 8'h00 yields cmd=16'h4000.
- Send a byte with stop bit forced 0 → frm_err pulse. The next two good bytes 8'h51, 8'h12 assemble as 16'h5112, so there is no byte misalignment.
- Leave 16'h43F1 unconsumed, then send 8'h60, 8'h00 → cmd_rdy drops when the 8'h60 completes and rises again with cmd=16'h6000.
- Assert rst_n low mid-way through a received byte and mid-way through a transmitted byte → TX=1 and cmd_rdy=0 immediately. After release, a clean 8'h43, 8'hF1 assembles correctly.
